// File: rtl/bp_read_control.sv
// DDR-to-BP-buffer loader: issues one DDR read per conf and writes 2*Line_width beats
// into two consecutive MAC groups. Optional XOR checksum under `BP_READ_CHECKSUM_EN.
module bp_read_control #(
  parameter int unsigned X_MAC            = 4,
  parameter int unsigned X_MESH           = 16,
  parameter int unsigned DDR_ADDR_LEN     = 32,
  parameter int unsigned ADDR_LEN         = 16,
  parameter int unsigned DATA_LEN         = 16,
  parameter int unsigned C_AXI_DATA_WIDTH = 256,
  parameter int unsigned SINGLE_LEN       = 24,
  parameter int unsigned BUFFER_NUM       = X_MAC * X_MESH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             conf,
  input  logic [SINGLE_LEN-1:0]            data_ddr_byte,
  input  logic [DDR_ADDR_LEN-1:0]          ddr_st_addr,
  input  logic [ADDR_LEN-1:0]              BP_st_addr,
  input  logic [1:0]                       BP_st_num,
  input  logic [SINGLE_LEN-1:0]            Line_width,
  output logic [DDR_ADDR_LEN-1:0]          ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]            ddr_len,
  output logic                             ddr_conf,
  input  logic [C_AXI_DATA_WIDTH-1:0]      ddr_read_data_in,
  input  logic                             ddr_read_valid,
  output logic                             ddr_read_ready,
  output logic [ADDR_LEN*BUFFER_NUM-1:0]   BP_addr_out,
  output logic [DATA_LEN*BUFFER_NUM-1:0]   BP_data_out,
  output logic [BUFFER_NUM-1:0]            BP_wr_en,
  output logic [C_AXI_DATA_WIDTH-1:0]      rd_checksum,
  output logic                             idle
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LINE0, S_LINE1} state_t;

  state_t                    r_state, w_state;
  logic [1:0]                r_group, w_group;
  logic [ADDR_LEN-1:0]       r_addr, w_addr;
  logic [SINGLE_LEN-1:0]     r_cnt, w_cnt;
  logic [SINGLE_LEN-1:0]     r_width, w_width;
  logic [ADDR_LEN-1:0]       r_st_addr, w_st_addr;
  logic [DDR_ADDR_LEN-1:0]   r_ddr_addr, w_ddr_addr;
  logic [SINGLE_LEN-1:0]     r_ddr_len, w_ddr_len;
  logic                      r_ddr_conf, w_ddr_conf;

  logic                      r_wr_vld;
  logic [1:0]                r_wr_grp;
  logic [ADDR_LEN-1:0]       r_wr_addr;
  logic [C_AXI_DATA_WIDTH-1:0] r_wr_data;

  logic w_ready;
  logic w_accept;
  logic w_last;

  assign w_ready  = (r_state == S_LINE0) || (r_state == S_LINE1);
  assign w_accept = w_ready && ddr_read_valid;
  assign w_last   = (r_cnt == r_width - SINGLE_LEN'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_group    <= 2'd0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_width    <= '0;
      r_st_addr  <= '0;
      r_ddr_addr <= '0;
      r_ddr_len  <= '0;
      r_ddr_conf <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_group    <= w_group;
      r_addr     <= w_addr;
      r_cnt      <= w_cnt;
      r_width    <= w_width;
      r_st_addr  <= w_st_addr;
      r_ddr_addr <= w_ddr_addr;
      r_ddr_len  <= w_ddr_len;
      r_ddr_conf <= w_ddr_conf;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_group    = r_group;
    w_addr     = r_addr;
    w_cnt      = r_cnt;
    w_width    = r_width;
    w_st_addr  = r_st_addr;
    w_ddr_addr = r_ddr_addr;
    w_ddr_len  = r_ddr_len;
    w_ddr_conf = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Start only once the last write strobe has drained (idle high).
        if (conf && !r_wr_vld && (Line_width != '0)) begin
          w_state    = S_REQ;
          w_group    = BP_st_num;
          w_addr     = BP_st_addr;
          w_cnt      = '0;
          w_width    = Line_width;
          w_st_addr  = BP_st_addr;
          w_ddr_addr = ddr_st_addr;
          w_ddr_len  = data_ddr_byte;
          w_ddr_conf = 1'b1;
        end
      end
      S_REQ: w_state = S_LINE0;
      S_LINE0, S_LINE1: begin
        if (w_accept) begin
          w_addr = r_addr + ADDR_LEN'(1);
          w_cnt  = r_cnt + SINGLE_LEN'(1);
          if (w_last) begin
            if (r_state == S_LINE0) begin
              w_state = S_LINE1;
              w_group = r_group + 2'd1;
              w_addr  = r_st_addr;
              w_cnt   = '0;
            end else begin
              w_state = S_IDLE;
            end
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // One-cycle write pipeline stage: beat accepted at k is written at k+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_vld  <= 1'b0;
      r_wr_grp  <= 2'd0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_vld <= w_accept;
      if (w_accept) begin
        r_wr_grp  <= r_group;
        r_wr_addr <= r_addr;
        r_wr_data <= ddr_read_data_in;
      end
    end
  end

  // Buffer i = n + m*X_MAC takes lane m; only group n strobes.
  for (genvar i = 0; i < int'(BUFFER_NUM); i++) begin : g_buf
    assign BP_wr_en[i] = r_wr_vld && (r_wr_grp == 2'(i % int'(X_MAC)));
    assign BP_addr_out[i*ADDR_LEN +: ADDR_LEN] = r_wr_addr;
    assign BP_data_out[i*DATA_LEN +: DATA_LEN] =
      r_wr_data[(i / int'(X_MAC))*DATA_LEN +: DATA_LEN];
  end

`ifdef BP_READ_CHECKSUM_EN
  logic [C_AXI_DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_ddr_conf) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ ddr_read_data_in;
    end
  end

  assign rd_checksum = r_checksum;
`else
  assign rd_checksum = '0;
`endif

  assign ddr_st_addr_out = r_ddr_addr;
  assign ddr_len         = r_ddr_len;
  assign ddr_conf        = r_ddr_conf;
  assign ddr_read_ready  = w_ready;
  assign idle            = (r_state == S_IDLE) && !r_wr_vld;

endmodule

// File: tb/tb_bp_read_control.sv
// Randomized bench for bp_read_control: a beat-index reference model predicts every
// strobe, address, data lane, ready/idle and checksum.
module tb_bp_read_control;

  logic          clk = 1'b0;
  logic          rst;
  logic          conf;
  logic [23:0]   data_ddr_byte;
  logic [31:0]   ddr_st_addr;
  logic [15:0]   BP_st_addr;
  logic [1:0]    BP_st_num;
  logic [23:0]   Line_width;
  logic [31:0]   ddr_st_addr_out;
  logic [23:0]   ddr_len;
  logic          ddr_conf;
  logic [255:0]  ddr_read_data_in;
  logic          ddr_read_valid;
  logic          ddr_read_ready;
  logic [1023:0] BP_addr_out;
  logic [1023:0] BP_data_out;
  logic [63:0]   BP_wr_en;
  logic [255:0]  rd_checksum;
  logic          idle;

  int n_cmp  = 0;
  int n_fail = 0;

  bp_read_control dut (
    .clk(clk), .rst(rst), .conf(conf), .data_ddr_byte(data_ddr_byte),
    .ddr_st_addr(ddr_st_addr), .BP_st_addr(BP_st_addr), .BP_st_num(BP_st_num),
    .Line_width(Line_width), .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len),
    .ddr_conf(ddr_conf), .ddr_read_data_in(ddr_read_data_in),
    .ddr_read_valid(ddr_read_valid), .ddr_read_ready(ddr_read_ready),
    .BP_addr_out(BP_addr_out), .BP_data_out(BP_data_out), .BP_wr_en(BP_wr_en),
    .rd_checksum(rd_checksum), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_beat();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  // mode: 0 continuous valid, 1 random valid, 2 valid pattern 1,0,0, 3 one-hot beats
  task automatic run_xfer(input int st_num, input int st_addr, input int w,
                          input int mode, input bit inj_conf);
    logic [31:0]   dda;
    logic [23:0]   dlen;
    logic [255:0]  cks, beat, pend_data, exp_cks;
    logic [63:0]   e_en;
    logic [1023:0] e_addr, e_data;
    logic [15:0]   a;
    logic [1:0]    g;
    int            acc, pend_idx;
    bit            pend, done, v;
    dda  = $urandom;
    dlen = 24'($urandom);
    @(negedge clk);
    chk("idle_before_conf", 1024'(idle), 1024'(1));
    conf = 1'b1; ddr_st_addr = dda; data_ddr_byte = dlen;
    BP_st_addr = 16'(st_addr); BP_st_num = 2'(st_num); Line_width = 24'(w);
    ddr_read_valid = 1'b0;
    @(negedge clk);
    conf = 1'b0;
    ddr_st_addr = $urandom; data_ddr_byte = 24'($urandom);
    BP_st_addr = 16'($urandom); BP_st_num = 2'($urandom); Line_width = 24'($urandom);
    chk("ddr_conf_pulse", 1024'(ddr_conf), 1024'(1));
    chk("ddr_st_addr_out", 1024'(ddr_st_addr_out), 1024'(dda));
    chk("ddr_len", 1024'(ddr_len), 1024'(dlen));
    chk("ready_in_req", 1024'(ddr_read_ready), 1024'(0));
    chk("idle_in_req", 1024'(idle), 1024'(0));
    acc = 0; pend = 1'b0; pend_idx = 0; pend_data = '0; cks = '0; done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      chk("ddr_conf_low", 1024'(ddr_conf), 1024'(0));
      chk("ready", 1024'(ddr_read_ready), 1024'(acc < 2*w));
      chk("idle", 1024'(idle), 1024'(acc == 2*w && !pend));
      if (pend) begin
        g = 2'(st_num + pend_idx / w);
        a = 16'(st_addr + pend_idx % w);
        e_en = '0;
        for (int m = 0; m < 16; m++) e_en[int'(g) + m*4] = 1'b1;
        for (int i = 0; i < 64; i++) begin
          e_addr[i*16 +: 16] = a;
          e_data[i*16 +: 16] = pend_data[(i/4)*16 +: 16];
        end
        chk("wr_en", 1024'(BP_wr_en), 1024'(e_en));
        chk("wr_addr", BP_addr_out, e_addr);
        chk("wr_data", BP_data_out, e_data);
      end else begin
        chk("wr_en_quiet", 1024'(BP_wr_en), 1024'(0));
      end
      if (acc == 2*w && !pend) begin
`ifdef BP_READ_CHECKSUM_EN
        exp_cks = cks;
`else
        exp_cks = '0;
`endif
        chk("rd_checksum", 1024'(rd_checksum), 1024'(exp_cks));
        done = 1'b1;
        break;
      end
      pend = 1'b0;
      case (mode)
        1:       v = ($urandom_range(0, 1) == 1);
        2:       v = (cyc % 3 == 0);
        default: v = 1'b1;
      endcase
      if (acc >= 2*w) v = 1'b1;
      beat = (mode == 3) ? (256'(1) << acc) : rand_beat();
      ddr_read_valid   = v;
      ddr_read_data_in = beat;
      conf = inj_conf && (cyc == 2);
      if (conf) Line_width = 24'($urandom_range(1, 9));
      if (v && acc < 2*w) begin
        pend = 1'b1; pend_idx = acc; pend_data = beat; cks ^= beat; acc++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $error("FAIL xfer_timeout: observed accepted=%0d expected %0d", acc, 2*w);
    end
    ddr_read_valid = 1'b0;
    conf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; conf = 1'b0; data_ddr_byte = '0; ddr_st_addr = '0; BP_st_addr = '0;
    BP_st_num = '0; Line_width = '0; ddr_read_data_in = '0; ddr_read_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_idle", 1024'(idle), 1024'(1));
    chk("rst_wr_en", 1024'(BP_wr_en), 1024'(0));
    chk("rst_ddr_conf", 1024'(ddr_conf), 1024'(0));
    chk("rst_ready", 1024'(ddr_read_ready), 1024'(0));
    chk("rst_ddr_addr", 1024'(ddr_st_addr_out), 1024'(0));
    chk("rst_ddr_len", 1024'(ddr_len), 1024'(0));
    chk("rst_bp_addr", BP_addr_out, 1024'(0));
    chk("rst_cks", 1024'(rd_checksum), 1024'(0));
    rst = 1'b0;

    run_xfer(1, 16'h0010, 3, 0, 1'b0);
    run_xfer(3, int'($urandom_range(0, 16'hFFFF)), 2, 0, 1'b0);
    run_xfer(2, 16'hFFFE, 4, 2, 1'b0);

    // Zero width: nothing happens
    @(negedge clk);
    conf = 1'b1; Line_width = '0; BP_st_num = 2'd1;
    @(negedge clk);
    conf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("zw_ddr_conf", 1024'(ddr_conf), 1024'(0));
      chk("zw_wr_en", 1024'(BP_wr_en), 1024'(0));
      chk("zw_idle", 1024'(idle), 1024'(1));
      @(negedge clk);
    end

    run_xfer(0, int'($urandom_range(0, 16'hFFFF)), 3, 1, 1'b1);

    // Reset after two accepted beats of six
    @(negedge clk);
    conf = 1'b1; Line_width = 24'd3; BP_st_num = 2'd0; BP_st_addr = 16'h0040;
    @(negedge clk);
    conf = 1'b0; ddr_read_valid = 1'b1; ddr_read_data_in = rand_beat();
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_writing", 1024'(|BP_wr_en), 1024'(1));
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 1024'(BP_wr_en), 1024'(0));
    chk("midrst_idle", 1024'(idle), 1024'(1));
    chk("midrst_ready", 1024'(ddr_read_ready), 1024'(0));
    @(negedge clk);
    rst = 1'b0; ddr_read_valid = 1'b0;

    run_xfer(1, 16'h0020, 3, 0, 1'b0);
    run_xfer(2, 16'h0100, 2, 3, 1'b0);
    for (int t = 0; t < 4; t++)
      run_xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)),
               int'($urandom_range(1, 5)), 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
